// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a
// DEPTH-entry FIFO of {address, instruction} pairs toward decode.
package fetch_unit_pkg;
   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_STEP = 2'd1,
      PC_JUMP = 2'd2
   } pc_ctl_t;
endpackage

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] pc_addr,
   input  logic        pc_misaligned,
   output pc_ctl_t     pc_ctl,
   input  logic        jump_req,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_addr,
   output logic        fault
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_FAULT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [31:0]     buf_data_q [DEPTH];
   logic [31:0]     buf_addr_q [DEPTH];

   logic can_req, handshake, push, pop, flush;

   assign can_req   = !Reset && (state_q == S_REQ) && (count_q < CW'(DEPTH))
                      && !pc_misaligned && !jump_req;
   assign handshake = can_req && mem_req_ready;
   assign flush     = !Reset && jump_req && (state_q != S_FAULT);
   assign push      = !Reset && (state_q == S_WAIT) && mem_rsp_valid && !jump_req;
   assign pop       = inst_valid && inst_ready;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_REQ;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         req_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         req_addr_q <= req_addr_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= mem_rsp_data;
         buf_addr_q[wr_ptr_q] <= req_addr_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_REQ: begin
            if (jump_req)           state_d = S_REQ;
            else if (pc_misaligned) state_d = S_FAULT;
            else if (handshake)     state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) state_d = S_REQ;
            else if (jump_req) state_d = S_DRAIN;
         end
         // A response landing together with a jump still retires the request.
         S_DRAIN: begin
            if (mem_rsp_valid) state_d = S_REQ;
         end
         default: state_d = S_FAULT;
      endcase
   end

   always_comb begin
      mem_req_valid = can_req;
      mem_req_addr  = pc_addr;
      pc_ctl        = PC_HOLD;
      if (flush)          pc_ctl = PC_JUMP;
      else if (handshake) pc_ctl = PC_STEP;
      fault      = !Reset && (state_q == S_FAULT);
      inst_valid = !Reset && (count_q != '0);
      inst_data  = buf_data_q[rd_ptr_q];
      inst_addr  = buf_addr_q[rd_ptr_q];
   end

   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      req_addr_d = handshake ? pc_addr : req_addr_q;
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

endmodule
